// File: rtl/prog_fifo_if.sv
// Handshake/status bundle for prog_fifo; master = producer/consumer side, slave = FIFO side.
interface prog_fifo_if #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             write_en;
   logic [WIDTH-1:0] write_data;
   logic             read_en;
   logic [WIDTH-1:0] read_data;
   logic [CW-1:0]    af_thresh;
   logic [CW-1:0]    ae_thresh;
   logic [CW-1:0]    count;
   logic             full;
   logic             almost_full;
   logic             empty;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;
   logic             clear_err;

   modport master (
      output flush, write_en, write_data, read_en, af_thresh, ae_thresh, clear_err,
      input  read_data, count, full, almost_full, empty, almost_empty, overflow, underflow
   );

   modport slave (
      input  flush, write_en, write_data, read_en, af_thresh, ae_thresh, clear_err,
      output read_data, count, full, almost_full, empty, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/prog_fifo.sv
// Single-clock FIFO with programmable almost-full/empty thresholds, sticky error flags and flush.
// Define PROG_FIFO_FWFT_EN for first-word-fall-through read_data; default is registered read.
module prog_fifo #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   prog_fifo_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_full;
   logic             w_empty;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic             w_wr_rej;
   logic             w_rd_rej;
   logic [CW-1:0]    w_count_nxt;
   logic             w_overflow_nxt;
   logic             w_underflow_nxt;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // Flush swallows both requests, so nothing is moved and no error is raised that cycle.
   assign w_rd_acc = bus.read_en & ~w_empty & ~bus.flush;
   assign w_wr_acc = bus.write_en & (~w_full | w_rd_acc) & ~bus.flush;
   assign w_wr_rej = bus.write_en & ~w_wr_acc & ~bus.flush;
   assign w_rd_rej = bus.read_en & ~w_rd_acc & ~bus.flush;

   always_comb begin
      w_count_nxt = r_count;
      if (bus.flush) begin
         w_count_nxt = '0;
      end else if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + CW'(1);
      end else if (!w_wr_acc && w_rd_acc) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   // A fresh error in the same cycle as clear_err keeps the flag set.
   always_comb begin
      w_overflow_nxt  = (r_overflow & ~bus.clear_err) | w_wr_rej;
      w_underflow_nxt = (r_underflow & ~bus.clear_err) | w_rd_rej;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_overflow  <= w_overflow_nxt;
         r_underflow <= w_underflow_nxt;
         if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= bus.write_data;
   end

`ifdef PROG_FIFO_FWFT_EN
   assign bus.read_data = w_empty ? '0 : r_mem[r_rd_ptr];
`else
   logic [WIDTH-1:0] r_read_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_read_data <= '0;
      end else if (w_rd_acc) begin
         r_read_data <= r_mem[r_rd_ptr];
      end
   end

   assign bus.read_data = r_read_data;
`endif

   assign bus.count        = r_count;
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.almost_full  = (r_count >= bus.af_thresh);
   assign bus.almost_empty = (r_count <= bus.ae_thresh);
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_prog_fifo.sv
// Directed self-checking bench for prog_fifo (DEPTH=32, WIDTH=8); works in both read modes.
module tb_prog_fifo;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   prog_fifo_if #(.DEPTH(32), .WIDTH(8)) bus ();

   prog_fifo #(.DEPTH(32), .WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; checks happen a further ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.write_en  = 1'b0;
      bus.read_en   = 1'b0;
      bus.flush     = 1'b0;
      bus.clear_err = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      bus.write_en   = 1'b1;
      bus.write_data = d;
      tick();
      bus.write_en   = 1'b0;
      settle();
   endtask

   task automatic pop_word(input string tag, input logic [7:0] exp);
`ifdef PROG_FIFO_FWFT_EN
      settle();
      check(tag, 32'(bus.read_data), 32'(exp));
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
      settle();
`else
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
      settle();
      check(tag, 32'(bus.read_data), 32'(exp));
`endif
   endtask

   initial begin
      n_checks       = 0;
      n_fails        = 0;
      idle();
      bus.write_data = 8'h00;
      bus.af_thresh  = 6'd28;
      bus.ae_thresh  = 6'd4;
      reset          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      settle();

      // 1: reset state, then 5 in / 5 out
      check("rst_count", 32'(bus.count), 0);
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_full", 32'(bus.full), 0);
      check("rst_rdata", 32'(bus.read_data), 0);
      check("rst_ovf", 32'(bus.overflow), 0);
      check("rst_udf", 32'(bus.underflow), 0);
      check("rst_ae", 32'(bus.almost_empty), 1);
      check("rst_af", 32'(bus.almost_full), 0);
      push(8'h01);
`ifdef PROG_FIFO_FWFT_EN
      check("fwft_first", 32'(bus.read_data), 32'h01);
`endif
      for (int i = 2; i <= 4; i++) push(8'(i));
      check("t1_ae_at4", 32'(bus.almost_empty), 1);
      push(8'h05);
      check("t1_count5", 32'(bus.count), 5);
      check("t1_ae_at5", 32'(bus.almost_empty), 0);
      pop_word("t1_pop1", 8'h01);
      check("t1_ae_back", 32'(bus.almost_empty), 1);
      for (int i = 2; i <= 5; i++) pop_word("t1_pop", 8'(i));
      check("t1_count0", 32'(bus.count), 0);
      check("t1_empty", 32'(bus.empty), 1);

      // 2: overfill with 33 words
      for (int i = 0; i < 33; i++) begin
         push(8'(8'h11 + i));
         check("t2_af", 32'(bus.almost_full), ((i + 1) >= 28) ? 1 : 0);
         if (i == 31) begin
            check("t2_full", 32'(bus.full), 1);
            check("t2_no_ovf", 32'(bus.overflow), 0);
         end
      end
      check("t2_count", 32'(bus.count), 32);
      check("t2_ovf", 32'(bus.overflow), 1);
      bus.clear_err = 1'b1;
      tick();
      bus.clear_err = 1'b0;
      settle();
      check("t2_clr_ovf", 32'(bus.overflow), 0);

      // 3: simultaneous read+write at full
      bus.write_data = 8'hA5;
      bus.write_en   = 1'b1;
`ifdef PROG_FIFO_FWFT_EN
      settle();
      check("t3_head", 32'(bus.read_data), 32'h11);
`endif
      bus.read_en = 1'b1;
      tick();
      idle();
      settle();
`ifndef PROG_FIFO_FWFT_EN
      check("t3_head", 32'(bus.read_data), 32'h11);
`endif
      check("t3_count", 32'(bus.count), 32);
      check("t3_ovf", 32'(bus.overflow), 0);
      for (int i = 0; i < 31; i++) pop_word("t3_drain", 8'(8'h12 + i));
      pop_word("t3_last", 8'hA5);
      check("t3_empty", 32'(bus.empty), 1);

      // 4: underflow handling
      bus.read_en = 1'b1;
      tick();
      bus.read_en = 1'b0;
      settle();
      check("t4_udf", 32'(bus.underflow), 1);
      check("t4_count", 32'(bus.count), 0);
      bus.read_en   = 1'b1;
      bus.clear_err = 1'b1;
      tick();
      idle();
      settle();
      check("t4_err_wins", 32'(bus.underflow), 1);
      bus.clear_err = 1'b1;
      tick();
      idle();
      settle();
      check("t4_clr", 32'(bus.underflow), 0);
      bus.write_data = 8'h77;
      bus.write_en   = 1'b1;
      bus.read_en    = 1'b1;
      tick();
      idle();
      settle();
      check("t4_rw_count", 32'(bus.count), 1);
      check("t4_rw_udf", 32'(bus.underflow), 1);
`ifdef PROG_FIFO_FWFT_EN
      check("t4_rw_rdata", 32'(bus.read_data), 32'h77);
`else
      check("t4_rw_rdata", 32'(bus.read_data), 32'hA5);
`endif
      bus.clear_err = 1'b1;
      tick();
      idle();
      pop_word("t4_pop", 8'h77);

      // 5: threshold change and flush
      for (int i = 0; i < 10; i++) push(8'(8'h80 + i));
      check("t5_af28", 32'(bus.almost_full), 0);
      bus.af_thresh = 6'd8;
      settle();
      check("t5_af8", 32'(bus.almost_full), 1);
      bus.af_thresh = 6'd28;
      settle();
      check("t5_af_back", 32'(bus.almost_full), 0);
      bus.flush      = 1'b1;
      bus.write_en   = 1'b1;
      bus.write_data = 8'hEE;
      tick();
      idle();
      settle();
      check("t5_count", 32'(bus.count), 0);
      check("t5_empty", 32'(bus.empty), 1);
      check("t5_ovf", 32'(bus.overflow), 0);
`ifdef PROG_FIFO_FWFT_EN
      check("t5_rdata", 32'(bus.read_data), 0);
`else
      check("t5_rdata", 32'(bus.read_data), 32'h77);
`endif
      bus.af_thresh = 6'd0;
      settle();
      check("t5_af0", 32'(bus.almost_full), 1);
      bus.af_thresh = 6'd28;

      // 6: continuous streaming across pointer wrap
      for (int j = 0; j <= 100; j++) begin
         bus.write_en   = (j < 100);
         bus.write_data = 8'(8'h40 + j);
         bus.read_en    = (j > 0);
`ifdef PROG_FIFO_FWFT_EN
         settle();
         if (j > 0) check("t6_data", 32'(bus.read_data), 32'(8'(8'h40 + j - 1)));
`endif
         tick();
`ifndef PROG_FIFO_FWFT_EN
         settle();
         if (j > 0) check("t6_data", 32'(bus.read_data), 32'(8'(8'h40 + j - 1)));
`endif
         if (j > 0 && j < 100) check("t6_count", 32'(bus.count), 1);
      end
      idle();
      settle();
      check("t6_empty", 32'(bus.empty), 1);
      check("t6_udf", 32'(bus.underflow), 0);

      // 7: asynchronous reset mid-operation
      push(8'h01);
      push(8'h02);
      pop_word("t7_pop", 8'h01);
      #2;
      reset = 1'b1;
      #1;
      check("t7_count", 32'(bus.count), 0);
      check("t7_empty", 32'(bus.empty), 1);
      check("t7_rdata", 32'(bus.read_data), 0);
      tick();
      reset = 1'b0;
      settle();
      push(8'h3C);
      pop_word("t7_after", 8'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
